// File: rtl/lap_recorder.sv
// Lap/split-time capture for the stopwatch: stores up to DEPTH laps, freezes the
// display briefly after each capture and lets the user browse stored laps.
module lap_recorder #(
    parameter int unsigned DEPTH      = 8,
    parameter int unsigned TIME_W     = 24,
    parameter int unsigned HOLD_TICKS = 1000
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clk_en,
    input  logic                    counting,
    input  logic                    reset_timer,
    input  logic [TIME_W-1:0]       time_in,
    input  logic                    lap_btn,
    input  logic                    recall_btn,
    output logic [TIME_W-1:0]       disp_time,
    output logic [3:0]              disp_lap_idx,
    output logic [$clog2(DEPTH):0]  lap_count,
    output logic                    lap_mode,
    output logic                    full
);

    localparam int unsigned PTR_W  = $clog2(DEPTH);
    localparam int unsigned CNT_W  = PTR_W + 1;
    localparam int unsigned HOLD_W = $clog2(HOLD_TICKS);

    typedef enum logic [1:0] {
        LIVE   = 2'd0,
        HOLD   = 2'd1,
        RECALL = 2'd2
    } state_t;

    state_t              state, state_n;
    logic [PTR_W-1:0]    wr_ptr, wr_ptr_n;
    logic [PTR_W-1:0]    rd_idx, rd_idx_n;
    logic [CNT_W-1:0]    lap_count_n;
    logic [HOLD_W-1:0]   hold_cnt, hold_cnt_n;
    logic                prev_lap, prev_rec;
    logic                tick_seen;
    logic                wr_en;
    logic                lap_edge, rec_edge, can_cap;
    logic [PTR_W-1:0]    last_idx;
    logic [TIME_W-1:0]   lap_mem [DEPTH];

    assign lap_edge = prev_lap & ~lap_btn;
    assign rec_edge = prev_rec & ~recall_btn;
    assign full     = (lap_count == CNT_W'(DEPTH));
    assign can_cap  = lap_edge & counting & ~full;
    assign last_idx = PTR_W'(lap_count - CNT_W'(1));

    // Next-state logic; everything except rst is qualified by clk_en.
    always_comb begin
        state_n     = state;
        wr_ptr_n    = wr_ptr;
        rd_idx_n    = rd_idx;
        lap_count_n = lap_count;
        hold_cnt_n  = hold_cnt;
        wr_en       = 1'b0;
        if (clk_en) begin
            if (reset_timer) begin
                state_n     = LIVE;
                wr_ptr_n    = '0;
                rd_idx_n    = '0;
                lap_count_n = '0;
                hold_cnt_n  = '0;
            end else begin
                case (state)
                    LIVE, HOLD: begin
                        if (can_cap) begin
                            wr_en       = 1'b1;
                            wr_ptr_n    = wr_ptr + PTR_W'(1);
                            lap_count_n = lap_count + CNT_W'(1);
                            hold_cnt_n  = HOLD_W'(HOLD_TICKS - 1);
                            state_n     = HOLD;
                        end else if (state == HOLD) begin
                            if (hold_cnt == '0) state_n = LIVE;
                            else                hold_cnt_n = hold_cnt - HOLD_W'(1);
                        end else if (rec_edge && lap_count != '0) begin
                            rd_idx_n = '0;
                            state_n  = RECALL;
                        end
                    end
                    RECALL: begin
                        if (rec_edge) begin
                            if (CNT_W'(rd_idx) == lap_count - CNT_W'(1)) begin
                                rd_idx_n = '0;
                                state_n  = LIVE;
                            end else begin
                                rd_idx_n = rd_idx + PTR_W'(1);
                            end
                        end
                    end
                    default: state_n = LIVE;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= LIVE;
            wr_ptr    <= '0;
            rd_idx    <= '0;
            lap_count <= '0;
            hold_cnt  <= '0;
            prev_lap  <= 1'b1;
            prev_rec  <= 1'b1;
            tick_seen <= 1'b0;
        end else begin
            state     <= state_n;
            wr_ptr    <= wr_ptr_n;
            rd_idx    <= rd_idx_n;
            lap_count <= lap_count_n;
            hold_cnt  <= hold_cnt_n;
            if (clk_en) begin
                prev_lap  <= lap_btn;
                prev_rec  <= recall_btn;
                tick_seen <= 1'b1;
            end
        end
    end

    // Lap storage is never cleared; lap_count defines which entries are valid.
    always_ff @(posedge clk) begin
        if (wr_en) lap_mem[wr_ptr] <= time_in;
    end

    // Live time is blanked until the first tick so the display reads zero out of reset.
    always_comb begin
        disp_time    = '0;
        disp_lap_idx = '0;
        lap_mode     = 1'b0;
        case (state)
            LIVE: begin
                if (tick_seen) disp_time = time_in;
            end
            HOLD: begin
                disp_time    = lap_mem[last_idx];
                disp_lap_idx = 4'(lap_count);
                lap_mode     = 1'b1;
            end
            RECALL: begin
                disp_time    = lap_mem[rd_idx];
                disp_lap_idx = 4'(CNT_W'(rd_idx) + CNT_W'(1));
                lap_mode     = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_lap_recorder.sv
// Self-checking bench for lap_recorder: table of per-tick vectors fed through a
// scoreboard queue, plus hand sequences for reset and clk_en gating.
module tb_lap_recorder;

    logic        clk = 1'b0;
    logic        rst;
    logic        clk_en;
    logic        counting;
    logic        reset_timer;
    logic [23:0] time_in;
    logic        lap_btn;
    logic        recall_btn;
    logic [23:0] disp_time;
    logic [3:0]  disp_lap_idx;
    logic [3:0]  lap_count;
    logic        lap_mode;
    logic        full;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic        c;
        logic        rt;
        logic        lap;
        logic        rec;
        logic [23:0] tin;
        logic [23:0] e_time;
        logic [3:0]  e_idx;
        logic [3:0]  e_cnt;
        logic        e_mode;
        logic        e_full;
    } vec_t;

    vec_t tbl[$];
    vec_t sb[$];

    lap_recorder #(.DEPTH(8), .TIME_W(24), .HOLD_TICKS(1000)) dut (
        .clk(clk), .rst(rst), .clk_en(clk_en), .counting(counting),
        .reset_timer(reset_timer), .time_in(time_in), .lap_btn(lap_btn),
        .recall_btn(recall_btn), .disp_time(disp_time), .disp_lap_idx(disp_lap_idx),
        .lap_count(lap_count), .lap_mode(lap_mode), .full(full)
    );

    always #10 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    function automatic void chk(string nm, int id, logic [23:0] act, logic [23:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s[%0d]: got %h want %h", nm, id, act, exp);
        end
    endfunction

    function automatic vec_t mk(logic c, logic rt, logic lap, logic rec, logic [23:0] tin,
                                logic [23:0] et, logic [3:0] ei, logic [3:0] ec, logic em);
        vec_t v;
        v.c = c; v.rt = rt; v.lap = lap; v.rec = rec; v.tin = tin;
        v.e_time = et; v.e_idx = ei; v.e_cnt = ec; v.e_mode = em;
        v.e_full = (ec == 4'd8);
        return v;
    endfunction

    // Ticks 1..1000 after a capture: frozen on val through tick 999, live at tick 1000.
    function automatic void push_hold(logic [23:0] val, logic [3:0] cnt, logic c,
                                      logic [23:0] tin, int rec_at);
        for (int k = 1; k <= 1000; k++) begin
            logic rec;
            rec = (k == rec_at) ? 1'b0 : 1'b1;
            if (k < 1000) tbl.push_back(mk(c, 1'b0, 1'b1, rec, tin, val, cnt, cnt, 1'b1));
            else          tbl.push_back(mk(c, 1'b0, 1'b1, rec, tin, tin, 4'd0, cnt, 1'b0));
        end
    endfunction

    function automatic void check_out(int id, vec_t e);
        chk("disp_time", id, disp_time, e.e_time);
        chk("disp_lap_idx", id, 24'(disp_lap_idx), 24'(e.e_idx));
        chk("lap_count", id, 24'(lap_count), 24'(e.e_cnt));
        chk("lap_mode", id, 24'(lap_mode), 24'(e.e_mode));
        chk("full", id, 24'(full), 24'(e.e_full));
    endfunction

    // One clk_en tick with the vector's inputs, then one idle cycle.
    task automatic apply(input int id, input vec_t v);
        counting = v.c; reset_timer = v.rt; lap_btn = v.lap; recall_btn = v.rec;
        time_in = v.tin; clk_en = 1'b1;
        sb.push_back(v);
        @(negedge clk);
        clk_en = 1'b0;
        if (sb.size() == 0) begin
            errors++; checks++;
            $display("FAIL scoreboard[%0d]: got empty want entry", id);
        end else begin
            check_out(id, sb.pop_front());
        end
        @(negedge clk);
    endtask

    initial begin
        vec_t rv;
        rv = mk(1'b0, 1'b0, 1'b1, 1'b1, 24'h0, 24'h0, 4'd0, 4'd0, 1'b0);

        // Single capture and hold expiry
        tbl.push_back(mk(1, 0, 1, 1, 24'h001234, 24'h001234, 0, 0, 0));
        tbl.push_back(mk(1, 0, 0, 1, 24'h001234, 24'h001234, 1, 1, 1));
        push_hold(24'h001234, 4'd1, 1'b1, 24'h005555, -1);
        tbl.push_back(mk(1, 1, 1, 1, 24'h000010, 24'h000010, 0, 0, 0));
        // Fill to DEPTH, then a ninth press that must not write
        for (int i = 1; i <= 8; i++) begin
            logic [23:0] v;
            v = 24'(i) << 8;
            tbl.push_back(mk(1, 0, 0, 1, v, v, 4'(i), 4'(i), 1));
            tbl.push_back(mk(1, 0, 1, 1, 24'h000050, v, 4'(i), 4'(i), 1));
        end
        tbl.push_back(mk(1, 0, 0, 1, 24'h009999, 24'h000800, 8, 8, 1));
        tbl.push_back(mk(1, 0, 1, 1, 24'h009999, 24'h000800, 8, 8, 1));
        tbl.push_back(mk(1, 1, 1, 1, 24'h000042, 24'h000042, 0, 0, 0));
        // Three laps, recall ignored mid-hold, then browse with an ignored lap press
        tbl.push_back(mk(1, 0, 0, 1, 24'h000100, 24'h000100, 1, 1, 1));
        tbl.push_back(mk(1, 0, 1, 1, 24'h000150, 24'h000100, 1, 1, 1));
        tbl.push_back(mk(1, 0, 0, 1, 24'h000200, 24'h000200, 2, 2, 1));
        tbl.push_back(mk(1, 0, 1, 1, 24'h000250, 24'h000200, 2, 2, 1));
        tbl.push_back(mk(1, 0, 0, 1, 24'h000300, 24'h000300, 3, 3, 1));
        push_hold(24'h000300, 4'd3, 1'b0, 24'h000777, 500);
        tbl.push_back(mk(0, 0, 1, 0, 24'h000777, 24'h000100, 1, 3, 1));
        tbl.push_back(mk(0, 0, 1, 1, 24'h000777, 24'h000100, 1, 3, 1));
        tbl.push_back(mk(1, 0, 0, 1, 24'h000777, 24'h000100, 1, 3, 1));
        tbl.push_back(mk(0, 0, 1, 1, 24'h000777, 24'h000100, 1, 3, 1));
        tbl.push_back(mk(0, 0, 1, 0, 24'h000777, 24'h000200, 2, 3, 1));
        tbl.push_back(mk(0, 0, 1, 1, 24'h000777, 24'h000200, 2, 3, 1));
        tbl.push_back(mk(0, 0, 1, 0, 24'h000777, 24'h000300, 3, 3, 1));
        tbl.push_back(mk(0, 0, 1, 1, 24'h000777, 24'h000300, 3, 3, 1));
        tbl.push_back(mk(0, 0, 1, 0, 24'h000777, 24'h000777, 0, 3, 0));
        tbl.push_back(mk(0, 0, 1, 1, 24'h000777, 24'h000777, 0, 3, 0));
        // Recall to lap 2, then reset_timer with a simultaneous lap press
        tbl.push_back(mk(1, 0, 1, 0, 24'h000777, 24'h000100, 1, 3, 1));
        tbl.push_back(mk(1, 0, 1, 1, 24'h000777, 24'h000100, 1, 3, 1));
        tbl.push_back(mk(1, 0, 1, 0, 24'h000777, 24'h000200, 2, 3, 1));
        tbl.push_back(mk(1, 0, 1, 1, 24'h000777, 24'h000200, 2, 3, 1));
        tbl.push_back(mk(1, 1, 0, 1, 24'h000055, 24'h000055, 0, 0, 0));
        tbl.push_back(mk(1, 0, 1, 1, 24'h000056, 24'h000056, 0, 0, 0));
        // Empty recall and stopped-lap press are both ignored
        tbl.push_back(mk(1, 0, 1, 0, 24'h000057, 24'h000057, 0, 0, 0));
        tbl.push_back(mk(1, 0, 1, 1, 24'h000057, 24'h000057, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 1, 24'h000058, 24'h000058, 0, 0, 0));
        tbl.push_back(mk(0, 0, 1, 1, 24'h000058, 24'h000058, 0, 0, 0));
        // Two laps, wait for live, then lap+recall together: lap wins
        tbl.push_back(mk(1, 0, 0, 1, 24'h001000, 24'h001000, 1, 1, 1));
        tbl.push_back(mk(1, 0, 1, 1, 24'h001100, 24'h001000, 1, 1, 1));
        tbl.push_back(mk(1, 0, 0, 1, 24'h002000, 24'h002000, 2, 2, 1));
        push_hold(24'h002000, 4'd2, 1'b1, 24'h002500, -1);
        tbl.push_back(mk(1, 0, 0, 0, 24'h003000, 24'h003000, 3, 3, 1));

        rst = 1'b1; clk_en = 1'b0; counting = 1'b0; reset_timer = 1'b0;
        lap_btn = 1'b1; recall_btn = 1'b1; time_in = 24'h00abcd;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check_out(-1, rv);

        for (int i = 0; i < tbl.size(); i++) apply(i, tbl[i]);

        // Synchronous reset in the middle of a hold
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_out(-2, rv);

        // A press between ticks is invisible to the edge detector
        apply(-3, mk(1, 0, 1, 1, 24'h000321, 24'h000321, 0, 0, 0));
        lap_btn = 1'b0;
        repeat (3) @(negedge clk);
        lap_btn = 1'b1;
        @(negedge clk);
        chk("gated_count", -4, 24'(lap_count), 24'h0);
        chk("gated_mode", -4, 24'(lap_mode), 24'h0);
        apply(-5, mk(1, 0, 1, 1, 24'h000322, 24'h000322, 0, 0, 0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/lap_recorder.md
Name: lap_recorder

Overview:
- Lap/split-time controller for the DE10-Lite stopwatch.
- Sits between the stopwatch control FSM / BCD time counter and the seven-segment display driver.
- Captures the running time into a small lap buffer on a lap-button press and briefly freezes the display on the captured value.
- Lets the user step through the stored laps with a recall button; otherwise passes live time through to the display.

Parameters:
- DEPTH, 8, number of lap entries stored (power of two, 2..16)
- TIME_W, 24, width of a time value: 6 BCD digits MM:SS:CC, 4 bits each, MSD first
- HOLD_TICKS, 1000, clk_en ticks the display freezes after a capture (1 s at 1 kHz)

Ports:
- clk  in  1  50 MHz system clock
- rst  in  1  synchronous, active-high reset
- clk_en  in  1  ~1 kHz single-cycle enable; all state updates qualified by it except rst
- counting  in  1  high while the stopwatch is running
- reset_timer  in  1  high while the user holds stopwatch reset
- time_in  in  TIME_W  current live BCD time
- lap_btn  in  1  lap button, active-low, debounced
- recall_btn  in  1  recall button, active-low, debounced
- disp_time  out  TIME_W  value to show on the display
- disp_lap_idx  out  4  1-based lap number shown; 0 when showing live time
- lap_count  out  $clog2(DEPTH)+1  number of stored laps, 0..DEPTH
- lap_mode  out  1  high when disp_time is a stored/held value, not live
- full  out  1  high when lap_count == DEPTH

Behaviour:
- Reset (rst=1 at a clk edge):
  - state = LIVE; lap_count = 0; wr_ptr = 0; rd_idx = 0; hold_cnt = 0.
  - Edge-detect registers = 1 (released).
  - Outputs: disp_time = 0, disp_lap_idx = 0, lap_mode = 0, full = 0.
  - Buffer contents need not be cleared.
- Edge detect: lap_edge = prev_lap & ~lap_btn; recall_edge likewise. Prev registers sample only on clk_en ticks, so a press registers once per falling edge at tick rate.
- States:
  - LIVE: disp_time = time_in (combinational pass-through), disp_lap_idx = 0, lap_mode = 0.
  - HOLD: disp_time = buf[last written], disp_lap_idx = that lap number, lap_mode = 1.
  - RECALL: disp_time = buf[rd_idx], disp_lap_idx = rd_idx+1, lap_mode = 1.
- Transitions, evaluated on clk_en ticks:
  - LIVE + lap_edge + counting + !full: write time_in into buf[wr_ptr], increment wr_ptr and lap_count, hold_cnt = HOLD_TICKS-1, go to HOLD. The written value is time_in sampled on that same tick.
  - LIVE + lap_edge with !counting or full: ignored. No write, count unchanged.
  - LIVE + recall_edge + lap_count > 0: rd_idx = 0, go to RECALL. With lap_count == 0: ignored.
  - HOLD: hold_cnt decrements each tick; at 0, go to LIVE.
  - HOLD + lap_edge: a new capture is allowed (same conditions as LIVE); it restarts hold_cnt.
  - HOLD + recall_edge: ignored.
  - RECALL + recall_edge: rd_idx++. If rd_idx was lap_count-1, go to LIVE and set rd_idx = 0.
  - RECALL + lap_edge: ignored (no capture while browsing).
- Simultaneous lap_edge and recall_edge in LIVE: lap wins if its capture conditions hold; otherwise recall is processed.
- reset_timer = 1 on a clk_en tick, from any state:
  - lap_count = 0, wr_ptr = 0, rd_idx = 0, state = LIVE.
  - Has priority over both button edges on the same tick.
- full is combinational from lap_count. No wrap-around: the buffer never overwrites.
- lap_count, pointers and state are untouched on cycles without clk_en (rst excepted).
- Latency: a capture is visible on disp_time the clk cycle after the capturing clk_en tick.

Test Plan:
- Reset, counting=1, time_in=0x001234, lap press → after tick: lap_count=1, lap_mode=1, disp_time=0x001234, disp_lap_idx=1. After 1000 ticks: lap_mode=0, disp_time follows time_in.
- Counting, 9 lap presses with DEPTH=8 → lap_count=8, full=1. 9th press: no write, buf[7] keeps the 8th captured value.
- Store 3 laps (0x000100, 0x000200, 0x000300), counting=0, 4 recall presses → disp_lap_idx 1,2,3 then 0. disp_time 0x000100, 0x000200, 0x000300, then live. lap_mode 1,1,1,0.
- lap_count=0, recall press → stays LIVE, disp_lap_idx=0. counting=0, lap press → lap_count stays 0.
- In RECALL at lap 2, reset_timer=1 for one tick with a simultaneous lap press → lap_count=0, full=0, LIVE, no capture.
- Lap and recall pressed on the same tick in LIVE while counting with 2 laps stored → capture occurs (lap_count=3), state HOLD, recall ignored. Mid-HOLD rst=1 → all outputs at reset values next cycle.
